// File: rtl/k_and_s_pkg.sv
// k_and_s_pkg: shared RAM arbiter types and default widths.
package k_and_s_pkg;
    localparam int ARB_ADDR_W = 5;
    localparam int ARB_DATA_W = 16;
    typedef enum logic [1:0] {ARB_IDLE, ARB_ACCESS, ARB_RESP} arb_state_t;
    typedef enum logic {OWN_CORE, OWN_LDR} arb_owner_t;
endpackage

// File: rtl/arb_select.sv
// arb_select: picks the RAM owner from pending requests.
// K_AND_S_ARB_RR_EN selects round-robin; otherwise the loader has fixed priority.
module arb_select
    import k_and_s_pkg::*;
(
    input  logic       core_req,
    input  logic       ldr_req,
    input  arb_owner_t last_grant,
    output arb_owner_t owner
);
`ifdef K_AND_S_ARB_RR_EN
    assign owner = (core_req && ldr_req) ? ((last_grant == OWN_LDR) ? OWN_CORE : OWN_LDR)
                                         : (ldr_req ? OWN_LDR : OWN_CORE);
`else
    assign owner = ldr_req ? OWN_LDR : OWN_CORE;
`endif
endmodule

// File: rtl/ram_port_arbiter.sv
// ram_port_arbiter: serialises core and loader accesses onto one single-port RAM.
// Arbitration rule set by K_AND_S_ARB_RR_EN (see arb_select).
module ram_port_arbiter
    import k_and_s_pkg::*;
#(
    parameter int ADDR_W = ARB_ADDR_W,
    parameter int DATA_W = ARB_DATA_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              core_req,
    input  logic              core_we,
    input  logic [ADDR_W-1:0] core_addr,
    input  logic [DATA_W-1:0] core_wdata,
    output logic              core_ack,
    output logic [DATA_W-1:0] core_rdata,
    input  logic              ldr_req,
    input  logic              ldr_we,
    input  logic [ADDR_W-1:0] ldr_addr,
    input  logic [DATA_W-1:0] ldr_wdata,
    output logic              ldr_ack,
    output logic [DATA_W-1:0] ldr_rdata,
    output logic              ram_en,
    output logic              ram_we,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_wdata,
    input  logic [DATA_W-1:0] ram_rdata,
    output logic              busy
);
    arb_state_t        state;
    arb_owner_t        owner_q, last_grant, sel;
    logic              we_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q, core_rdata_q, ldr_rdata_q;
    logic              access, resp, done;

    arb_select u_sel (
        .core_req  (core_req),
        .ldr_req   (ldr_req),
        .last_grant(last_grant),
        .owner     (sel)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= ARB_IDLE;
            owner_q      <= OWN_CORE;
            last_grant   <= OWN_CORE;
            we_q         <= 1'b0;
            addr_q       <= '0;
            wdata_q      <= '0;
            core_rdata_q <= '0;
            ldr_rdata_q  <= '0;
        end else begin
            case (state)
                ARB_IDLE: begin
                    if (core_req || ldr_req) begin
                        state      <= ARB_ACCESS;
                        owner_q    <= sel;
                        last_grant <= sel;
                        we_q       <= (sel == OWN_LDR) ? ldr_we : core_we;
                        addr_q     <= (sel == OWN_LDR) ? ldr_addr : core_addr;
                        wdata_q    <= (sel == OWN_LDR) ? ldr_wdata : core_wdata;
                    end
                end
                ARB_ACCESS: state <= we_q ? ARB_IDLE : ARB_RESP;
                ARB_RESP: begin
                    state <= ARB_IDLE;
                    if (owner_q == OWN_LDR) ldr_rdata_q <= ram_rdata;
                    else core_rdata_q <= ram_rdata;
                end
                default: state <= ARB_IDLE;
            endcase
        end
    end

    // Outputs decode registered state only, so reset clears them without a clock edge.
    assign access     = (state == ARB_ACCESS);
    assign resp       = (state == ARB_RESP);
    assign done       = (access && we_q) || resp;
    assign ram_en     = access;
    assign ram_we     = access && we_q;
    assign ram_addr   = access ? addr_q : '0;
    assign ram_wdata  = access ? wdata_q : '0;
    assign core_ack   = done && (owner_q == OWN_CORE);
    assign ldr_ack    = done && (owner_q == OWN_LDR);
    // Read data is forwarded in the ack cycle, then held by the owner's register.
    assign core_rdata = (resp && owner_q == OWN_CORE) ? ram_rdata : core_rdata_q;
    assign ldr_rdata  = (resp && owner_q == OWN_LDR) ? ram_rdata : ldr_rdata_q;
    assign busy       = (state != ARB_IDLE);
endmodule

// File: tb/tb_ram_port_arbiter.sv
// tb_ram_port_arbiter: directed vectors and corner sequences for ram_port_arbiter.
module tb_ram_port_arbiter;
`ifdef K_AND_S_ARB_RR_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif
    logic        clk = 0, rst_n = 0;
    logic        core_req = 0, core_we = 0, ldr_req = 0, ldr_we = 0;
    logic [4:0]  core_addr = 0, ldr_addr = 0;
    logic [15:0] core_wdata = 0, ldr_wdata = 0;
    logic        core_ack, ldr_ack, ram_en, ram_we, busy;
    logic [15:0] core_rdata, ldr_rdata, ram_wdata;
    logic [15:0] ram_rdata = 0;
    logic [4:0]  ram_addr;
    logic [15:0] mem [32];
    int          tests = 0, fails = 0;
    bit          lg = 0;
    logic [15:0] exp_core_rd = 0, exp_ldr_rd = 0;

    typedef struct {
        bit          who;
        bit          we;
        logic [4:0]  addr;
        logic [15:0] wdata;
        logic [15:0] rdata;
        int          lat;
    } vec_t;
    vec_t vecs [10];

    ram_port_arbiter dut (
        .clk(clk), .rst_n(rst_n),
        .core_req(core_req), .core_we(core_we), .core_addr(core_addr), .core_wdata(core_wdata),
        .core_ack(core_ack), .core_rdata(core_rdata),
        .ldr_req(ldr_req), .ldr_we(ldr_we), .ldr_addr(ldr_addr), .ldr_wdata(ldr_wdata),
        .ldr_ack(ldr_ack), .ldr_rdata(ldr_rdata),
        .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
        .ram_rdata(ram_rdata), .busy(busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (ram_en) begin
            if (ram_we) mem[ram_addr] <= ram_wdata;
            else ram_rdata <= mem[ram_addr];
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic xfer(input bit who, input bit we, input logic [4:0] a, input logic [15:0] d,
                        input logic [15:0] er, input int lat, input bit drop_early);
        int  cyc = 0;
        bit  got = 0;
        @(negedge clk);
        if (who) begin ldr_req = 1; ldr_we = we; ldr_addr = a; ldr_wdata = d; end
        else begin core_req = 1; core_we = we; core_addr = a; core_wdata = d; end
        while (!got && cyc < 8) begin
            @(posedge clk); #1; cyc++;
            if (cyc == 1) begin
                check("ram_en_access", ram_en, 1);
                check("ram_we_access", ram_we, we);
                check("ram_addr_access", ram_addr, a);
                if (we) check("ram_wdata_access", ram_wdata, d);
                if (drop_early) begin core_req = 0; ldr_req = 0; end
            end
            check("other_ack_quiet", who ? core_ack : ldr_ack, 0);
            if (who ? ldr_ack : core_ack) begin
                got = 1;
                core_req = 0; ldr_req = 0;
            end
        end
        check("ack_latency", got ? cyc : 99, lat);
        if (!we) begin
            if (who) exp_ldr_rd = er; else exp_core_rd = er;
        end
        check("core_rdata", core_rdata, exp_core_rd);
        check("ldr_rdata", ldr_rdata, exp_ldr_rd);
        @(posedge clk); #1;
        check("busy_fall", busy, 0);
        check("rdata_hold", who ? ldr_rdata : core_rdata, who ? exp_ldr_rd : exp_core_rd);
        lg = who;
    endtask

    task automatic pair();
        int  cyc = 0, tc = 0, tl = 0;
        bit  first = RR ? !lg : 1'b1;
        @(negedge clk);
        core_req = 1; core_we = 0; core_addr = 5'h03;
        ldr_req = 1; ldr_we = 0; ldr_addr = 5'h10;
        while ((tc == 0 || tl == 0) && cyc < 12) begin
            @(posedge clk); #1; cyc++;
            check("acks_exclusive", core_ack && ldr_ack, 0);
            if (core_ack) begin tc = cyc; core_req = 0; end
            if (ldr_ack) begin tl = cyc; ldr_req = 0; end
        end
        check("pair_first_ack", first ? tl : tc, 2);
        check("pair_second_ack", first ? tc : tl, 5);
        check("pair_core_rdata", core_rdata, 16'hBEEF);
        check("pair_ldr_rdata", ldr_rdata, 16'h1234);
        exp_core_rd = 16'hBEEF;
        exp_ldr_rd = 16'h1234;
        lg = !first;
        @(posedge clk); #1;
    endtask

    initial begin
        int quiet;
        for (int i = 0; i < 32; i++) mem[i] = '0;
        vecs[0] = '{0, 1, 5'h03, 16'hBEEF, 16'h0000, 1};
        vecs[1] = '{0, 0, 5'h03, 16'h0000, 16'hBEEF, 2};
        vecs[2] = '{1, 1, 5'h10, 16'h1234, 16'h0000, 1};
        vecs[3] = '{1, 0, 5'h10, 16'h0000, 16'h1234, 2};
        vecs[4] = '{0, 1, 5'h1F, 16'hFFFF, 16'h0000, 1};
        vecs[5] = '{1, 0, 5'h1F, 16'h0000, 16'hFFFF, 2};
        vecs[6] = '{0, 1, 5'h00, 16'hA5A5, 16'h0000, 1};
        vecs[7] = '{0, 0, 5'h00, 16'h0000, 16'hA5A5, 2};
        vecs[8] = '{1, 1, 5'h0A, 16'h5A5A, 16'h0000, 1};
        vecs[9] = '{1, 0, 5'h0A, 16'h0000, 16'h5A5A, 2};
        #12;
        check("rst_busy", busy, 0);
        check("rst_ram_en", ram_en, 0);
        check("rst_ram_we", ram_we, 0);
        check("rst_ram_addr", ram_addr, 0);
        check("rst_acks", {core_ack, ldr_ack}, 0);
        check("rst_rdata", {core_rdata, ldr_rdata}, 0);
        @(negedge clk); rst_n = 1;
        for (int i = 0; i < 10; i++)
            xfer(vecs[i].who, vecs[i].we, vecs[i].addr, vecs[i].wdata, vecs[i].rdata, vecs[i].lat, 0);
        pair();
        pair();
        // Core read whose request drops right after grant.
        xfer(0, 0, 5'h1F, 16'h0000, 16'hFFFF, 2, 1);
        quiet = 0;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            quiet += int'(core_ack) + int'(ldr_ack) + int'(busy);
        end
        check("no_regrant_after_drop", quiet, 0);
        // Reset asserted during the access cycle of a write.
        @(negedge clk);
        core_req = 1; core_we = 1; core_addr = 5'h07; core_wdata = 16'h7777;
        @(posedge clk); #1;
        check("mid_write_we", ram_we, 1);
        rst_n = 0; core_req = 0;
        #1;
        check("abort_ram_en", ram_en, 0);
        check("abort_ram_we", ram_we, 0);
        check("abort_ack", core_ack, 0);
        check("abort_busy", busy, 0);
        check("abort_rdata", {core_rdata, ldr_rdata}, 0);
        @(negedge clk); rst_n = 1;
        @(posedge clk); #1;
        check("post_rst_idle", busy, 0);
        check("ram_unmodified", mem[7], 0);
        exp_core_rd = 0; exp_ldr_rd = 0; lg = 0;
        xfer(0, 0, 5'h07, 16'h0000, 16'h0000, 2, 0);
        xfer(1, 0, 5'h03, 16'h0000, 16'hBEEF, 2, 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
